// File: rtl/hja_step_ctrl.sv
// Debug execution controller: debounces step/run buttons and produces a CPU
// clock-enable for free run, single step or N-step bursts, with PC breakpoint halt.
module hja_step_ctrl #(
    parameter int DB_LIMIT = 50000,
    parameter int DB_W     = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_btn_step,
    input  logic        i_btn_run,
    input  logic [7:0]  i_sw_burst,
    input  logic        i_break_en,
    input  logic [15:0] i_break_pc,
    input  logic [15:0] i_if_pc,
    input  logic        i_clr_cnt,
    output logic        o_cpu_en,
    output logic        o_running,
    output logic        o_busy,
    output logic        o_bp_hit,
    output logic [15:0] o_step_count
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_BURST = 2'd2} state_t;

    localparam int BTN_STEP = 0;
    localparam int BTN_RUN  = 1;

    logic [1:0]           w_btn_raw;
    logic [1:0]           r_sync1, r_sync2, r_db, r_db_q;
    logic [1:0][DB_W-1:0] r_db_cnt;
    logic                 w_step_press, w_run_press, w_bp_match;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_burst_cnt;
    logic       w_cpu_en_nxt, w_running_nxt, w_busy_nxt, w_bp_hit_nxt;

    assign w_btn_raw = {i_btn_run, i_btn_step};

    // Counter only advances while the synced input disagrees with the accepted level
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_db     <= '0;
            r_db_q   <= '0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_db_q  <= r_db;
            for (int b = 0; b < 2; b++) begin
                if (r_sync2[b] == r_db[b]) begin
                    r_db_cnt[b] <= '0;
                end else if (r_db_cnt[b] == DB_W'(DB_LIMIT - 1)) begin
                    r_db[b]     <= r_sync2[b];
                    r_db_cnt[b] <= '0;
                end else begin
                    r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
                end
            end
        end
    end

    assign w_step_press = r_db[BTN_STEP] & ~r_db_q[BTN_STEP];
    assign w_run_press  = r_db[BTN_RUN]  & ~r_db_q[BTN_RUN];
    assign w_bp_match   = i_break_en && (i_if_pc == i_break_pc);

    always_ff @(posedge i_clk) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_run_press)                             w_state_nxt = S_RUN;
                else if (w_step_press && i_sw_burst != 8'd0) w_state_nxt = S_BURST;
            end
            S_RUN: begin
                if (w_bp_match || w_run_press) w_state_nxt = S_IDLE;
            end
            S_BURST: begin
                if (w_bp_match || w_run_press || r_burst_cnt == 8'd1) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; they track the next state directly
    always_comb begin
        w_running_nxt = (w_state_nxt == S_RUN);
        w_busy_nxt    = (w_state_nxt == S_BURST);
        w_cpu_en_nxt  = w_running_nxt || w_busy_nxt ||
                        (r_state == S_IDLE && w_step_press && !w_run_press &&
                         i_sw_burst == 8'd0);
        w_bp_hit_nxt  = o_bp_hit;
        if ((r_state == S_RUN || r_state == S_BURST) && w_bp_match)
            w_bp_hit_nxt = 1'b1;
        else if (r_state == S_IDLE && (w_run_press || w_step_press))
            w_bp_hit_nxt = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_burst_cnt  <= '0;
            o_cpu_en     <= 1'b0;
            o_running    <= 1'b0;
            o_busy       <= 1'b0;
            o_bp_hit     <= 1'b0;
            o_step_count <= '0;
        end else begin
            if (r_state == S_IDLE && w_state_nxt == S_BURST) r_burst_cnt <= i_sw_burst;
            else if (r_state == S_BURST)                     r_burst_cnt <= r_burst_cnt - 1'b1;
            o_cpu_en  <= w_cpu_en_nxt;
            o_running <= w_running_nxt;
            o_busy    <= w_busy_nxt;
            o_bp_hit  <= w_bp_hit_nxt;
            if (i_clr_cnt)     o_step_count <= '0;
            else if (o_cpu_en) o_step_count <= o_step_count + 1'b1;
        end
    end

endmodule
